// File: rtl/ugemm_seq_if.sv
// Control/status bundle between the GEMM sequencer and its host/array.
interface ugemm_seq_if #(
    parameter int unsigned HEIGHT = 32,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CWIDTH = 8
);
    logic              start;
    logic              abort;
    logic [CWIDTH-1:0] cfg_len;
    logic              cfg_reuse_w;
    logic [HEIGHT-1:0] en_i;
    logic [HEIGHT-1:0] clr_i;
    logic [HEIGHT-1:0] mac_done;
    logic [WIDTH-1:0]  en_w;
    logic [WIDTH-1:0]  clr_w;
    logic [WIDTH-1:0]  en_o;
    logic [WIDTH-1:0]  clr_o;
    logic              busy;
    logic              done;
    logic              err;

    // Host side: issues jobs, observes array controls and status.
    modport master (
        output start, abort, cfg_len, cfg_reuse_w,
        input  en_i, clr_i, mac_done, en_w, clr_w, en_o, clr_o, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  start, abort, cfg_len, cfg_reuse_w,
        output en_i, clr_i, mac_done, en_w, clr_w, en_o, clr_o, busy, done, err
    );
endinterface

// File: rtl/ugemm_seq.sv
// Job sequencer for a weight-stationary systolic GEMM array. Generates the
// index-0 control waveforms from a phase FSM and skews them one cycle per
// row/column through shift registers. Every output is a flop.
module ugemm_seq #(
    parameter int unsigned HEIGHT = 32,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CWIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    ugemm_seq_if.slave bus
);
    localparam int unsigned HW      = (HEIGHT > WIDTH) ? HEIGHT : WIDTH;
    localparam int unsigned HW_BITS = $clog2(HW + 1);
    localparam int unsigned CNT_W   = (HW_BITS > CWIDTH) ? HW_BITS : CWIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StLoadW,
        StCompute,
        StDrain,
        StFlush
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;     // remaining cycles in phase, minus one
    logic [CWIDTH-1:0]   len_q, len_d;
    logic                reuse_q, reuse_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [HEIGHT-1:0]   en_i_q, en_i_d;
    logic [HEIGHT-1:0]   clr_i_q, clr_i_d;
    logic [HEIGHT-1:0]   mac_done_q, mac_done_d;
    logic [WIDTH-1:0]    en_w_q, en_w_d;
    logic [WIDTH-1:0]    clr_w_q, clr_w_d;
    logic [WIDTH-1:0]    en_o_q, en_o_d;
    logic [WIDTH-1:0]    clr_o_q, clr_o_d;

    logic clr0, en_w0, clr_w0, en_i0, mac0, en_o0;

    // Phase FSM, index-0 waveform and skew pipelines (next-state).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        reuse_d = reuse_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                // busy_q is still high in the done cycle, so start is ignored there.
                if (bus.start && !busy_q) begin
                    if (bus.cfg_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StClr;
                        len_d   = bus.cfg_len;
                        reuse_d = bus.cfg_reuse_w;
                        cnt_d   = '0;
                    end
                end
            end
            StClr: begin
                if (reuse_q) begin
                    state_d = StCompute;
                    cnt_d   = CNT_W'(len_q) - CNT_W'(1);
                end else begin
                    state_d = StLoadW;
                    cnt_d   = CNT_W'(HEIGHT - 1);
                end
            end
            StLoadW: begin
                if (cnt_q == '0) begin
                    state_d = StCompute;
                    cnt_d   = CNT_W'(len_q) - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StCompute: begin
                if (cnt_q == '0) begin
                    state_d = StDrain;
                    cnt_d   = CNT_W'(HEIGHT - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StFlush;
                    cnt_d   = CNT_W'(WIDTH - 2);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StFlush: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides everything, including a coincident start.
        if (bus.abort) begin
            state_d = StIdle;
            cnt_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end

        // Index-0 controls follow the phase that will be current next cycle.
        clr0   = (state_d == StClr);
        clr_w0 = clr0 && !reuse_d;
        en_w0  = (state_d == StLoadW);
        en_i0  = (state_d == StCompute);
        mac0   = en_i0 && (cnt_d == '0);
        en_o0  = (state_d == StDrain);

        en_i_d     = {en_i_q[HEIGHT-2:0], en_i0};
        clr_i_d    = {clr_i_q[HEIGHT-2:0], clr0};
        mac_done_d = {mac_done_q[HEIGHT-2:0], mac0};
        en_w_d     = {en_w_q[WIDTH-2:0], en_w0};
        clr_w_d    = {clr_w_q[WIDTH-2:0], clr_w0};
        en_o_d     = {en_o_q[WIDTH-2:0], en_o0};
        clr_o_d    = {clr_o_q[WIDTH-2:0], clr0};

        if (bus.abort) begin
            en_i_d     = '0;
            clr_i_d    = '0;
            mac_done_d = '0;
            en_w_d     = '0;
            clr_w_d    = '0;
            en_o_d     = '0;
            clr_o_d    = '0;
        end

        busy_d = (state_d != StIdle) || done_d;
    end

    // State, counters and output registers; reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            len_q      <= '0;
            reuse_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            en_i_q     <= '0;
            clr_i_q    <= '0;
            mac_done_q <= '0;
            en_w_q     <= '0;
            clr_w_q    <= '0;
            en_o_q     <= '0;
            clr_o_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            reuse_q    <= reuse_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            en_i_q     <= en_i_d;
            clr_i_q    <= clr_i_d;
            mac_done_q <= mac_done_d;
            en_w_q     <= en_w_d;
            clr_w_q    <= clr_w_d;
            en_o_q     <= en_o_d;
            clr_o_q    <= clr_o_d;
        end
    end

    assign bus.en_i     = en_i_q;
    assign bus.clr_i    = clr_i_q;
    assign bus.mac_done = mac_done_q;
    assign bus.en_w     = en_w_q;
    assign bus.clr_w    = clr_w_q;
    assign bus.en_o     = en_o_q;
    assign bus.clr_o    = clr_o_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_ugemm_seq.sv
// Directed bench for ugemm_seq with HEIGHT=4, WIDTH=3, CWIDTH=8.
module tb_ugemm_seq;
    localparam int H  = 4;
    localparam int W  = 3;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ugemm_seq_if #(.HEIGHT(H), .WIDTH(W), .CWIDTH(CW)) bus ();

    ugemm_seq #(.HEIGHT(H), .WIDTH(W), .CWIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // All outputs packed; err is bit 0.
    logic [26:0] outs;
    assign outs = {bus.en_i, bus.clr_i, bus.mac_done, bus.en_w, bus.clr_w,
                   bus.en_o, bus.clr_o, bus.busy, bus.done, bus.err};

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected waveforms for job cycle c, built from the documented timeline.
    task automatic check_cycle(input int c, input int l, input bit reuse);
        int p;
        logic [H-1:0] ei, ci, md;
        logic [W-1:0] ew, cw, eo, co;
        p = reuse ? 1 : H + 1;
        for (int h = 0; h < H; h++) begin
            ei[h] = (c >= p + 1 + h) && (c <= p + l + h);
            ci[h] = (c == 1 + h);
            md[h] = (c == p + l + h);
        end
        for (int w = 0; w < W; w++) begin
            ew[w] = !reuse && (c >= 2 + w) && (c <= p + w);
            cw[w] = !reuse && (c == 1 + w);
            co[w] = (c == 1 + w);
            eo[w] = (c >= p + l + 1 + w) && (c <= p + l + H + w);
        end
        check_val($sformatf("en_i c%0d", c), bus.en_i, ei);
        check_val($sformatf("clr_i c%0d", c), bus.clr_i, ci);
        check_val($sformatf("mac_done c%0d", c), bus.mac_done, md);
        check_val($sformatf("en_w c%0d", c), bus.en_w, ew);
        check_val($sformatf("clr_w c%0d", c), bus.clr_w, cw);
        check_val($sformatf("en_o c%0d", c), bus.en_o, eo);
        check_val($sformatf("clr_o c%0d", c), bus.clr_o, co);
        check_val($sformatf("busy c%0d", c), bus.busy, (c >= 1) && (c <= p + l + H + W));
        check_val($sformatf("done c%0d", c), bus.done, c == p + l + H + W);
        check_val($sformatf("err c%0d", c), bus.err, 1'b0);
    endtask

    // Assumes the current cycle is job cycle 1; scrambles cfg mid-job.
    task automatic run_job(input int l, input bit reuse, input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            if (c == 3) begin
                bus.cfg_len     = 8'd1;
                bus.cfg_reuse_w = ~reuse;
            end
            check_cycle(c, l, reuse);
            step();
        end
    endtask

    task automatic kick(input int l, input bit reuse);
        bus.cfg_len     = CW'(l);
        bus.cfg_reuse_w = reuse;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.cfg_len     = '0;
        bus.cfg_reuse_w = 1'b0;
        #1;
        check_val("rst_outs", outs, 27'd0);
        #22 rst_n = 1'b1;
        step();
        check_val("idle_outs", outs, 27'd0);

        // Full job with weight load: done in cycle 20.
        kick(8, 1'b0);
        run_job(8, 1'b0, 24);

        // Reused weights: done in cycle 16.
        kick(8, 1'b1);
        run_job(8, 1'b1, 18);

        // Zero length is rejected with a single err pulse.
        kick(0, 1'b0);
        check_val("l0 c1", outs, 27'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("l0 after %0d", i), outs, 27'd0);
        end
        step();

        // Abort during cycle 10; restart at the following edge.
        kick(8, 1'b0);
        run_job(8, 1'b0, 9);
        check_cycle(10, 8, 1'b0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_val("abort c11", outs, 27'd0);
        kick(2, 1'b1);
        run_job(2, 1'b1, 14);

        // Abort and start at the same edge: nothing starts.
        bus.abort = 1'b1;
        kick(4, 1'b0);
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("abort_start %0d", i), outs, 27'd0);
            step();
        end

        // Asynchronous reset in cycle 7.
        kick(8, 1'b0);
        run_job(8, 1'b0, 6);
        #2 rst_n = 1'b0;
        #1 check_val("async_rst", outs, 27'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("post_rst %0d", i), outs, 27'd0);
        end

        // Start held high: second job accepted at the end of cycle 12.
        bus.cfg_len     = 8'd3;
        bus.cfg_reuse_w = 1'b1;
        bus.start       = 1'b1;
        step();
        for (int c = 1; c <= 11; c++) begin
            check_cycle(c, 3, 1'b1);
            step();
        end
        check_val("held_gap", outs, 27'd0);
        step();
        bus.start = 1'b0;
        run_job(3, 1'b1, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
